out_seq: RTL and testbench

Sequencer for the output layer of the network. Accepts one sample at a time through a valid/ready handshake and pulses the layer's input latch. It then waits out the perceptron forward latency, computes the per-neuron error (target − output) serially, and issues the single-cycle `wr` strobe that commits weight updates in training mode. It sits between the training-loop controller and the output-layer datapath, and also counts samples and epochs.

---
 rtl/nn_pkg.sv | 46 ++++
 rtl/err_unit.sv | 54 +++++
 rtl/out_seq.sv | 197 +++++++++++++++++++
 tb/tb_out_seq.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for the output-layer sequencer: state encoding,
// default fraction width and saturating add/sub helpers.
package nn_pkg;

  localparam int NN_FRAC = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FWD,
    ST_ERR,
    ST_UPD,
    ST_DONE
  } state_e;

  // Clamp a 65-bit intermediate into the signed range of a w-bit word
  // (w <= 64). The result is returned sign-extended to 64 bits.
  function automatic logic signed [63:0] sat_w(input logic signed [64:0] v, input int w);
    logic signed [64:0] hi;
    logic signed [64:0] lo;
    hi = (65'sd1 <<< (w - 1)) - 65'sd1;
    lo = -(65'sd1 <<< (w - 1));
    if (v > hi) return hi[63:0];
    else if (v < lo) return lo[63:0];
    else return v[63:0];
  endfunction

  // a + b saturated to w bits; operands are w-bit values sign-extended to 64
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int w);
    logic [64:0] s;
    s = {a[63], a} + {b[63], b};
    return sat_w(s, w);
  endfunction

  // a - b saturated to w bits; operands are w-bit values sign-extended to 64
  function automatic logic signed [63:0] sat_sub(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int w);
    logic [64:0] s;
    s = {a[63], a} - {b[63], b};
    return sat_w(s, w);
  endfunction

endpackage

// File: rtl/err_unit.sv
// Error unit: err = sat(t - o), shared across neurons by the sequencer.
// With OUT_SEQ_SSE_EN defined it also squares each error (rescaled by FRAC)
// and adds it into a saturating sum-of-squares accumulator.
module err_unit
  import nn_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FRAC  = NN_FRAC
) (
  input  logic signed [WIDTH-1:0]   i_t,
  input  logic signed [WIDTH-1:0]   i_o,
  output logic signed [WIDTH-1:0]   o_err
`ifdef OUT_SEQ_SSE_EN
  ,
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_acc_en,
  input  logic                      i_acc_clr,
  output logic signed [2*WIDTH-1:0] o_acc
`endif
);

  logic signed [63:0] diff;
  logic               unused_diff_hi;

  assign diff           = sat_sub(64'(i_t), 64'(i_o), WIDTH);
  assign o_err          = diff[WIDTH-1:0];
  assign unused_diff_hi = ^diff[63:WIDTH];

`ifdef OUT_SEQ_SSE_EN
  logic signed [2*WIDTH-1:0] sq;
  logic signed [2*WIDTH-1:0] sq_sh;
  logic signed [2*WIDTH-1:0] acc_q;
  logic signed [2*WIDTH-1:0] acc_d;

  assign sq    = (2*WIDTH)'(o_err) * (2*WIDTH)'(o_err);
  assign sq_sh = sq >>> FRAC;
  assign o_acc = acc_q;

  // next accumulator: clear on epoch wrap, saturating add on each ERR cycle
  always_comb begin
    acc_d = acc_q;
    if (i_acc_clr)     acc_d = '0;
    else if (i_acc_en) acc_d = (2*WIDTH)'(sat_add(64'(acc_q), 64'(sq_sh), 2*WIDTH));
  end

  // accumulator register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end
`endif

endmodule

// File: rtl/out_seq.sv
// Output-layer sequencer: accept a sample, strobe the input latch, wait the
// forward latency, compute per-neuron errors serially, optionally strobe the
// weight write, then hold the result until consumed. Counts samples/epochs.
// Optional feature macro: OUT_SEQ_SSE_EN (adds o_sse, per-epoch sum of squares).
module out_seq
  import nn_pkg::*;
#(
  parameter int NUM_PCTN  = 2,
  parameter int WIDTH     = 32,
  parameter int FRAC      = NN_FRAC,
  parameter int FWD_LAT   = 3,
  parameter int EPOCH_LEN = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic                           i_train,
  input  logic [NUM_PCTN*WIDTH-1:0]      i_t,
  input  logic                           i_abort,
  output logic                           o_ld,
  input  logic [NUM_PCTN*WIDTH-1:0]      i_o,
  output logic                           o_wr,
  output logic [NUM_PCTN*WIDTH-1:0]      o_err,
  output logic                           o_done,
  input  logic                           i_done_ready,
  output logic [$clog2(EPOCH_LEN):0]     o_cnt,
  output logic                           o_epoch
`ifdef OUT_SEQ_SSE_EN
  ,
  output logic signed [2*WIDTH-1:0]      o_sse
`endif
);

  localparam int CW  = $clog2(EPOCH_LEN) + 1;
  localparam int FCW = $clog2(FWD_LAT) + 1;
  localparam int IW  = (NUM_PCTN > 1) ? $clog2(NUM_PCTN) : 1;

  state_e                             state_q, state_d;
  logic [FCW-1:0]                     fcnt_q, fcnt_d;
  logic [IW-1:0]                      idx_q, idx_d;
  logic [NUM_PCTN-1:0][WIDTH-1:0]     t_q, t_d;
  logic                               train_q, train_d;
  logic [NUM_PCTN-1:0][WIDTH-1:0]     err_q, err_d;
  logic [CW-1:0]                      cnt_q, cnt_d;
  logic                               epoch_q, epoch_d;

  logic [NUM_PCTN-1:0][WIDTH-1:0]     io_v;
  logic signed [WIDTH-1:0]            err_w;

  assign io_v = i_o;

`ifdef OUT_SEQ_SSE_EN
  logic                               acc_en;
  logic                               acc_clr;
  logic signed [2*WIDTH-1:0]          acc_w;
  logic signed [2*WIDTH-1:0]          sse_q, sse_d;
`endif

  // one subtract/saturate unit, time-multiplexed over neurons by idx
  err_unit #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_err (
    .i_t       (t_q[idx_q]),
    .i_o       (io_v[idx_q]),
    .o_err     (err_w)
`ifdef OUT_SEQ_SSE_EN
    ,
    .clk       (clk),
    .rst       (rst),
    .i_acc_en  (acc_en),
    .i_acc_clr (acc_clr),
    .o_acc     (acc_w)
`endif
  );

  // next-state and datapath updates; abort overrides everything outside IDLE
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    idx_d   = idx_q;
    t_d     = t_q;
    train_d = train_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    epoch_d = 1'b0;
`ifdef OUT_SEQ_SSE_EN
    acc_en  = 1'b0;
    acc_clr = 1'b0;
    sse_d   = sse_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          t_d     = i_t;
          train_d = i_train;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        fcnt_d  = FCW'(FWD_LAT - 1);
        state_d = ST_FWD;
      end
      ST_FWD: begin
        if (fcnt_q == '0) begin
          idx_d   = '0;
          state_d = ST_ERR;
        end else begin
          fcnt_d = fcnt_q - 1'b1;
        end
      end
      ST_ERR: begin
        err_d[idx_q] = err_w;
`ifdef OUT_SEQ_SSE_EN
        acc_en = 1'b1;
`endif
        if (idx_q == IW'(NUM_PCTN - 1)) state_d = train_q ? ST_UPD : ST_DONE;
        else                            idx_d   = idx_q + 1'b1;
      end
      ST_UPD: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (i_done_ready) begin
          state_d = ST_IDLE;
          if (cnt_q == CW'(EPOCH_LEN - 1)) begin
            cnt_d   = '0;
            epoch_d = 1'b1;
`ifdef OUT_SEQ_SSE_EN
            sse_d   = acc_w;
            acc_clr = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // abort: drop the sample; errors already registered stay, counters frozen
    if (i_abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      err_d   = err_q;
      cnt_d   = cnt_q;
      epoch_d = 1'b0;
`ifdef OUT_SEQ_SSE_EN
      acc_en  = 1'b0;
      acc_clr = 1'b0;
      sse_d   = sse_q;
`endif
    end
  end

  // state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      fcnt_q  <= '0;
      idx_q   <= '0;
      t_q     <= '0;
      train_q <= 1'b0;
      err_q   <= '0;
      cnt_q   <= '0;
      epoch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      idx_q   <= idx_d;
      t_q     <= t_d;
      train_q <= train_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      epoch_q <= epoch_d;
    end
  end

`ifdef OUT_SEQ_SSE_EN
  // last completed epoch's sum of squared errors
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sse_q <= '0;
    else     sse_q <= sse_d;
  end

  assign o_sse = sse_q;
`endif

  assign o_ready = (state_q == ST_IDLE);
  assign o_ld    = (state_q == ST_LOAD);
  assign o_wr    = (state_q == ST_UPD) && !i_abort;
  assign o_done  = (state_q == ST_DONE);
  assign o_err   = err_q;
  assign o_cnt   = cnt_q;
  assign o_epoch = epoch_q;

endmodule

// File: tb/tb_out_seq.sv
// Scoreboard bench for out_seq: driver pushes expected results computed from
// a plain-arithmetic reference; a negedge monitor pops and compares on each
// result handshake and checks strobe timing relative to the latch pulse.
module tb_out_seq;

  localparam int NP   = 2;
  localparam int W    = 32;
  localparam int FRAC = 16;
  localparam int FL   = 3;
  localparam int EL   = 4;
  localparam int CW   = $clog2(EL) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_valid, o_ready, i_train, i_abort, o_ld, o_wr, o_done;
  logic              i_done_ready, o_epoch;
  logic [NP*W-1:0]   i_t, i_o, o_err;
  logic [CW-1:0]     o_cnt;
`ifdef OUT_SEQ_SSE_EN
  logic signed [2*W-1:0] o_sse;
`endif

  always #5 clk = ~clk;

  out_seq #(.NUM_PCTN(NP), .WIDTH(W), .FRAC(FRAC), .FWD_LAT(FL), .EPOCH_LEN(EL)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_train(i_train),
    .i_t(i_t), .i_abort(i_abort), .o_ld(o_ld), .i_o(i_o), .o_wr(o_wr), .o_err(o_err),
    .o_done(o_done), .i_done_ready(i_done_ready), .o_cnt(o_cnt), .o_epoch(o_epoch)
`ifdef OUT_SEQ_SSE_EN
    , .o_sse(o_sse)
`endif
  );

  typedef struct {
    logic [NP-1:0][W-1:0] err;
    bit                   train;
    int                   cnt;
    bit                   epoch;
    longint               sse;
  } exp_t;

  exp_t   q[$];
  int     n_pass = 0, n_total = 0;
  int     cyc = 0;
  int     m_cnt = 0, n_start = 0, n_ld = 0, n_ep_exp = 0, n_ep_seen = 0;
  longint m_acc = 0, m_sse = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // reference error: true difference clamped into the signed W-bit range
  function automatic logic [W-1:0] ref_err(input logic [W-1:0] t, input logic [W-1:0] o);
    longint d;
    d = longint'($signed(t)) - longint'($signed(o));
    if (d > 64'sd2147483647)  d = 64'sd2147483647;
    if (d < -64'sd2147483648) d = -64'sd2147483648;
    return d[W-1:0];
  endfunction

  // add each neuron's squared error (in Q format) to the model sum
  task automatic model_sse(input logic [NP-1:0][W-1:0] e);
    longint v, s;
    for (int n = 0; n < NP; n++) begin
      v = longint'($signed(e[n]));
      s = (v * v) / 65536;
      if (m_acc > 64'sh7FFF_FFFF_FFFF_FFFF - s) m_acc = 64'sh7FFF_FFFF_FFFF_FFFF;
      else m_acc = m_acc + s;
    end
  endtask

  task automatic start(input logic [NP*W-1:0] t, input logic [NP*W-1:0] o, input bit tr,
                       input bit noise);
    int k = 0;
    while (!o_ready && k < 200) begin @(posedge clk); #1; k++; end
    if (!o_ready) chk("ready_timeout", 0, 1);
    i_valid = 1'b1; i_t = t; i_o = o; i_train = tr;
    @(posedge clk); #1;
    i_valid = noise;
    if (noise) i_t = {$urandom, $urandom};
    n_start++;
  endtask

  task automatic run_sample(input logic [NP*W-1:0] t, input logic [NP*W-1:0] o, input bit tr,
                            input int hold, input bit noise);
    exp_t e;
    logic [NP-1:0][W-1:0] tv, ov;
    int k = 0;
    tv = t; ov = o;
    start(t, o, tr, noise);
    for (int n = 0; n < NP; n++) e.err[n] = ref_err(tv[n], ov[n]);
    model_sse(e.err);
    e.train = tr;
    e.cnt   = (m_cnt + 1) % EL;
    e.epoch = (m_cnt + 1 == EL);
    if (e.epoch) begin m_sse = m_acc; m_acc = 0; n_ep_exp++; end
    e.sse = m_sse;
    m_cnt = e.cnt;
    q.push_back(e);
    while (!o_done && k < 200) begin @(posedge clk); #1; k++; end
    i_valid = 1'b0;
    if (!o_done) chk("done_timeout", 0, 1);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("done_held", o_done, 1);
      chk("ready_low_in_done", o_ready, 0);
    end
    i_done_ready = 1'b1;
    @(posedge clk); #1;
    i_done_ready = 1'b0;
  endtask

  // monitor: strobe timing and result scoreboard
  initial begin
    int ld_cyc, acc_cyc, wr_cyc, done_cyc, wr_n;
    bit post;
    exp_t e, pe;
    ld_cyc = 0; acc_cyc = 0; wr_cyc = -1; done_cyc = -1; wr_n = 0; post = 0;
    forever begin
      @(negedge clk);
      if (rst) begin post = 0; continue; end
      if (post) begin
        chk("cnt_after_hs", o_cnt, pe.cnt[CW-1:0]);
        chk("epoch_pulse", o_epoch, pe.epoch);
`ifdef OUT_SEQ_SSE_EN
        if (pe.epoch) chk("sse_at_wrap", o_sse, pe.sse);
`endif
        post = 0;
      end
      if (o_epoch) n_ep_seen++;
      if (i_valid && o_ready) acc_cyc = cyc;
      if (o_ld) begin
        n_ld++;
        chk("ld_after_accept", 64'(cyc - acc_cyc), 1);
        ld_cyc = cyc; wr_n = 0; wr_cyc = -1; done_cyc = -1;
      end
      if (o_wr) begin wr_n++; wr_cyc = cyc; end
      if (o_done && done_cyc < 0) done_cyc = cyc;
      if (o_done && i_done_ready) begin
        if (q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = q.pop_front();
          chk("err", o_err, e.err);
          chk("wr_count", 64'(wr_n), 64'(e.train));
          chk("done_latency", 64'(done_cyc - ld_cyc), 64'(FL + NP + 1 + int'(e.train)));
          if (e.train) chk("wr_latency", 64'(wr_cyc - ld_cyc), 64'(FL + NP + 1));
          pe = e; post = 1;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got stall, expected completion");
    $fatal(1);
  end

  initial begin
    logic [NP-1:0][W-1:0] tv, ov;
    int k;
    rst = 1'b1; i_valid = 0; i_train = 0; i_t = '0; i_o = '0; i_abort = 0; i_done_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_ready", o_ready, 1);
    chk("rst_ld", o_ld, 0);
    chk("rst_wr", o_wr, 0);
    chk("rst_done", o_done, 0);
    chk("rst_epoch", o_epoch, 0);
    chk("rst_err", o_err, 0);
    chk("rst_cnt", o_cnt, 0);

    // t = {1.0, 0.5}, o = {0.25, 0.5}: inference, then training with held consumer
    tv[0] = 32'h0001_0000; tv[1] = 32'h0000_8000;
    ov[0] = 32'h0000_4000; ov[1] = 32'h0000_8000;
    run_sample(tv, ov, 1'b0, 0, 1'b0);
    chk("err_plan", o_err, {32'h0, 32'h0000_C000});
    run_sample(tv, ov, 1'b1, 5, 1'b0);

    // saturation both directions
    tv[0] = 32'h7FFF_FFFF; ov[0] = 32'h8000_0000;
    tv[1] = 32'h8000_0000; ov[1] = 32'h7FFF_FFFF;
    run_sample(tv, ov, 1'b0, 1, 1'b0);
    chk("sat_vals", o_err, {32'h8000_0000, 32'h7FFF_FFFF});

    // abort during UPD
    tv[0] = 32'h0000_3000; tv[1] = 32'hFFFF_0000;
    ov[0] = 32'h0000_1000; ov[1] = 32'h0000_2000;
    start(tv, ov, 1'b1, 1'b0);
    begin
      logic [NP-1:0][W-1:0] ae;
      for (int n = 0; n < NP; n++) ae[n] = ref_err(tv[n], ov[n]);
      model_sse(ae);
    end
    k = 0;
    while (!o_wr && k < 50) begin @(posedge clk); #1; k++; end
    if (!o_wr) chk("wr_timeout", 0, 1);
    i_abort = 1'b1;
    #1 chk("wr_gated_by_abort", o_wr, 0);
    @(posedge clk); #1;
    i_abort = 1'b0;
    chk("idle_after_abort", o_ready, 1);
    chk("cnt_after_abort", o_cnt, m_cnt[CW-1:0]);

    // asynchronous reset in the middle of FWD
    start(tv, ov, 1'b1, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("busy_in_fwd", o_ready, 0);
    rst = 1'b1;
    #1;
    chk("arst_ready", o_ready, 1);
    chk("arst_ld", o_ld, 0);
    chk("arst_done", o_done, 0);
    chk("arst_err", o_err, 0);
    chk("arst_cnt", o_cnt, 0);
`ifdef OUT_SEQ_SSE_EN
    chk("arst_sse", o_sse, 0);
`endif
    m_cnt = 0; m_acc = 0; m_sse = 0;
    @(posedge clk); #1 rst = 1'b0;

    // one epoch of errors of 0.5 on both neurons
    tv[0] = 32'h0001_0000; tv[1] = 32'h0001_0000;
    ov[0] = 32'h0000_8000; ov[1] = 32'h0000_8000;
    for (int s = 0; s < EL; s++) run_sample(tv, ov, s[0], 0, 1'b0);
    chk("cnt_wrapped", o_cnt, 0);
`ifdef OUT_SEQ_SSE_EN
    chk("sse_two", o_sse, 64'h2_0000);
`endif

    // randomized samples
    for (int s = 0; s < 40; s++) begin
      for (int n = 0; n < NP; n++) begin
        if ($urandom_range(0, 2) == 0) begin
          tv[n] = $urandom; ov[n] = $urandom;
        end else begin
          tv[n] = $urandom_range(0, 32'h3_FFFF) - 32'h2_0000;
          ov[n] = $urandom_range(0, 32'h3_FFFF) - 32'h2_0000;
        end
      end
      run_sample(tv, ov, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                 ($urandom_range(0, 3) == 0));
    end

    k = 0;
    while (q.size() != 0 && k < 20) begin @(posedge clk); #1; k++; end
    repeat (2) @(posedge clk);
    #1;
    chk("queue_drained", 64'(q.size()), 0);
    chk("ld_pulses", 64'(n_ld), 64'(n_start));
    chk("epoch_pulses", 64'(n_ep_seen), 64'(n_ep_exp));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
